// File: rtl/sat_ct_pkg.sv
// -----------------------------------------------------------------------------
// sat_ct_pkg
// Shared definitions for the clause table scheduler slice:
//   - state_e  : scheduler state encoding (IDLE=0 LOAD=1 RUN=2 DRAIN=3),
//                visible to software through state_o
//   - CNT_W    : width of each per-requester grant counter
//   - ct_width : row width of the clause table for a given configuration
// -----------------------------------------------------------------------------
package sat_ct_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Each clause stores NSAT-1 literals of (address + polarity) bits.
  function automatic int ct_width(input int var_addr_w, input int clause_count, input int nsat);
    return (var_addr_w + 1) * (nsat - 1) * clause_count;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Searches the request vector starting
// at ptr+1 (modulo NUM_REQ) and grants the first asserted requester.
// Ports:
//   req       in   NUM_REQ  request vector
//   ptr       in   ID_W     id of the most recently granted requester
//   gnt       out  NUM_REQ  one-hot grant, all zero when no request
//   gnt_id    out  ID_W     encoded id of the granted requester
//   gnt_valid out  1        a grant was issued
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid
);

  always_comb begin
    // NOTE: every output gets a default before any conditional assignment so
    // no path leaves a value unassigned, which would otherwise infer a latch.
    gnt       = '0;
    gnt_id    = '0;
    gnt_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin : scan
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
    if (gnt_valid) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/clause_table_scheduler.sv
// -----------------------------------------------------------------------------
// clause_table_scheduler
// Sequences and shares the clause table between the AXI config front end
// (LOAD: row writes forwarded to the table write port) and the walk/evaluator
// lanes (RUN: round-robin arbitration of NUM_REQ readers onto the single table
// read port, 1-cycle latency row routed back to the requester).
//
// Optional feature macro: CT_SCHED_STATS_EN enables per-requester 32-bit grant
// counters on grant_cnt_o; without it grant_cnt_o is tied to zero.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   load_start_i / load_done_i    IDLE->LOAD / LOAD->IDLE pulses
//   run_start_i / run_stop_i      IDLE->RUN / RUN->DRAIN pulses
//   axi_wr_en_i/addr_i/clauses_i  row write from AXI front end
//   req_valid_i, req_addr_i       per-requester read requests (packed addresses)
//   req_ready_o                   one-hot grant
//   rsp_valid_o, rsp_clauses_o    one-hot response strobe, shared row bus
//   ct_wr_en_o/addr_o/clauses_o   table write port
//   ct_rd_addr_o, ct_clauses_i    table read port (data one cycle after address)
//   state_o                       IDLE=0 LOAD=1 RUN=2 DRAIN=3
//   wr_err_o                      sticky: write attempted outside LOAD
//   grant_cnt_o                   packed per-requester grant counters
// -----------------------------------------------------------------------------
module clause_table_scheduler
  import sat_ct_pkg::*;
#(
  parameter  int NUM_REQ                = 4,
  parameter  int VARIABLE_ADDRESS_WIDTH = 11,
  parameter  int CLAUSE_COUNT           = 20,
  parameter  int NSAT                   = 3,
  localparam int CT_WIDTH = ct_width(VARIABLE_ADDRESS_WIDTH, CLAUSE_COUNT, NSAT)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                load_start_i,
  input  logic                                load_done_i,
  input  logic                                run_start_i,
  input  logic                                run_stop_i,
  input  logic                                axi_wr_en_i,
  input  logic [VARIABLE_ADDRESS_WIDTH-1:0]   axi_wr_addr_i,
  input  logic [CT_WIDTH-1:0]                 axi_wr_clauses_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ*VARIABLE_ADDRESS_WIDTH-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  output logic [CT_WIDTH-1:0]                 rsp_clauses_o,
  output logic                                ct_wr_en_o,
  output logic [VARIABLE_ADDRESS_WIDTH-1:0]   ct_wr_addr_o,
  output logic [CT_WIDTH-1:0]                 ct_wr_clauses_o,
  output logic [VARIABLE_ADDRESS_WIDTH-1:0]   ct_rd_addr_o,
  input  logic [CT_WIDTH-1:0]                 ct_clauses_i,
  output logic [1:0]                          state_o,
  output logic                                wr_err_o,
  output logic [NUM_REQ*CNT_W-1:0]            grant_cnt_o
);

  localparam int AW   = VARIABLE_ADDRESS_WIDTH;
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q;
  logic [AW-1:0]       last_addr_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic                wr_err_q;

  logic                arb_en;
  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_id;
  logic                gnt_valid;
  logic [AW-1:0]       gnt_addr;
  logic                load_accept;

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        // Load takes priority when both starts arrive together.
        if (load_start_i)     state_d = ST_LOAD;
        else if (run_start_i) state_d = ST_RUN;
      end
      ST_LOAD:  if (load_done_i) state_d = ST_IDLE;
      ST_RUN:   if (run_stop_i)  state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: all state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of statement order.
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  assign state_o     = state_q;
  assign load_accept = (state_q == ST_IDLE) && load_start_i;

  // ---------------------------------------------------------------------------
  // Table write path: only live while loading.
  // ---------------------------------------------------------------------------
  assign ct_wr_en_o      = axi_wr_en_i && (state_q == ST_LOAD) && !rst_i;
  assign ct_wr_addr_o    = axi_wr_addr_i;
  assign ct_wr_clauses_o = axi_wr_clauses_i;

  always_ff @(posedge clk_i) begin
    if (rst_i)                                     wr_err_q <= 1'b0;
    else if (axi_wr_en_i && state_q != ST_LOAD)    wr_err_q <= 1'b1;
  end

  assign wr_err_o = wr_err_q;

  // ---------------------------------------------------------------------------
  // Read arbitration. The stop cycle issues no grant so DRAIN only has to
  // deliver the response from the last real RUN grant.
  // ---------------------------------------------------------------------------
  assign arb_en  = (state_q == ST_RUN) && !run_stop_i && !rst_i;
  assign arb_req = arb_en ? req_valid_i : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (arb_req),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  assign gnt_addr     = req_addr_i[gnt_id*AW +: AW];
  assign req_ready_o  = gnt;
  // Read address follows the grant combinationally and parks on the last
  // granted row when idle, so the table port sees no spurious toggling.
  assign ct_rd_addr_o = gnt_valid ? gnt_addr : last_addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= ID_W'(NUM_REQ - 1);
      last_addr_q <= '0;
      rsp_valid_q <= '0;
    end else begin
      rsp_valid_q <= gnt;
      if (gnt_valid) begin
        ptr_q       <= gnt_id;
        last_addr_q <= gnt_addr;
      end
    end
  end

  // Table data arrives one cycle after the address, aligned with rsp_valid_q.
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_clauses_o = ct_clauses_i;

  // ---------------------------------------------------------------------------
  // Optional grant statistics
  // ---------------------------------------------------------------------------
`ifdef CT_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk_i) begin
    // NOTE: this counter array is small and software-visible, so it is
    // cleared on reset element by element rather than left undefined.
    if (rst_i || load_accept) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (gnt_valid) begin
      cnt_q[gnt_id] <= cnt_q[gnt_id] + 1'b1;
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`else
  assign grant_cnt_o = '0;
`endif

endmodule
